// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter command sequencer: shifter opcodes,
// request kind encodings and the sequencer state enum.
package shifter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int AMT_W_DEF  = 4;

  // Maximum amount the shifter datapath can apply in one cycle.
  localparam int MAX_STEP = 3;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  typedef enum logic [1:0] {
    KIND_LSL  = 2'b00,
    KIND_LSR  = 2'b01,
    KIND_ASR  = 2'b10,
    KIND_RSVD = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Map a request kind to the shifter opcode used for its shift steps.
  // The reserved kind never reaches SHIFT, so NOP is a safe fallback.
  function automatic logic [2:0] kind_to_op(kind_e kind);
    case (kind)
      KIND_LSL: kind_to_op = OP_LSL;
      KIND_LSR: kind_to_op = OP_LSR;
      KIND_ASR: kind_to_op = OP_ASR;
      default:  kind_to_op = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/shift_cmd_seq_if.sv
// Bundle of the request channel, the shifter command bus and the response
// channel. The slave side is the sequencer; the master side is whatever
// issues requests, models the shifter register and consumes responses.
interface shift_cmd_seq_if #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 4
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [AMT_W-1:0]  req_amt;
  logic [DATA_W-1:0] req_data;

  logic [2:0]        op;
  logic [1:0]        shamt;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_kind, req_amt, req_data, d_out, rsp_ready,
    output req_ready, op, shamt, d_in, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_kind, req_amt, req_data, d_out, rsp_ready,
    input  req_ready, op, shamt, d_in, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/shift_step_calc.sv
// Greedy step splitter: given the remaining shift amount, produce the step
// for this cycle (at most 3), the remainder after it, and whether it is last.
module shift_step_calc
  import shifter_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic [AMT_W-1:0] rem,
  output logic [1:0]       step,
  output logic [AMT_W-1:0] rem_next,
  output logic             last
);

  // Clamp to the per-cycle maximum; the step never exceeds rem so no wrap.
  always_comb begin
    step = 2'd0;
    if (rem > AMT_W'(MAX_STEP)) begin
      step = 2'(MAX_STEP);
    end else begin
      step = rem[1:0];
    end
    rem_next = rem - {{(AMT_W-2){1'b0}}, step};
    last     = (rem_next == '0);
  end

endmodule

// File: rtl/shift_cmd_seq.sv
// Command-side driver for the 8-bit shifter datapath. Takes one shift request,
// issues LOAD followed by greedy shift steps of at most 3, then returns the
// shifter output on the response channel.
module shift_cmd_seq
  import shifter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AMT_W  = AMT_W_DEF
) (
  input logic             clk,
  input logic             reset,
  shift_cmd_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  kind_e             kind_q, kind_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [1:0]        step;
  logic [AMT_W-1:0]  rem_after;
  logic              step_last;

  logic              req_ready_c;
  logic [2:0]        op_c;
  logic [1:0]        shamt_c;
  logic [DATA_W-1:0] d_in_c;
  logic              rsp_valid_c;
  logic [DATA_W-1:0] rsp_data_c;
  logic              rsp_err_c;

  shift_step_calc #(.AMT_W(AMT_W)) u_step (
    .rem      (rem_q),
    .step     (step),
    .rem_next (rem_after),
    .last     (step_last)
  );

  // State and capture registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      kind_q  <= KIND_LSL;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic and output decode from the current state.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    kind_d      = kind_q;
    data_d      = data_q;
    req_ready_c = 1'b0;
    op_c        = OP_NOP;
    shamt_c     = 2'd0;
    d_in_c      = '0;
    rsp_valid_c = 1'b0;
    rsp_data_c  = '0;
    rsp_err_c   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          kind_d  = kind_e'(bus.req_kind);
          rem_d   = bus.req_amt;
          data_d  = bus.req_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        op_c   = OP_LOAD;
        d_in_c = data_q;
        if ((rem_q != '0) && (kind_q != KIND_RSVD)) begin
          state_d = SHIFT;
        end else begin
          state_d = RESP;
        end
      end
      SHIFT: begin
        // Amounts beyond DATA_W still step all the way down; the shifter
        // saturates naturally to zero or sign copies.
        op_c    = kind_to_op(kind_q);
        shamt_c = step;
        rem_d   = rem_after;
        if (step_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // op stays NOP so d_out holds while the consumer stalls.
        rsp_valid_c = 1'b1;
        rsp_data_c  = bus.d_out;
        rsp_err_c   = (kind_q == KIND_RSVD);
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is asserted present a quiet bus regardless of state.
    if (reset) begin
      req_ready_c = 1'b0;
      op_c        = OP_NOP;
      shamt_c     = 2'd0;
      d_in_c      = '0;
      rsp_valid_c = 1'b0;
      rsp_data_c  = '0;
      rsp_err_c   = 1'b0;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.op        = op_c;
  assign bus.shamt     = shamt_c;
  assign bus.d_in      = d_in_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_c;
  assign bus.rsp_err   = rsp_err_c;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Bench for shift_cmd_seq: models the shifter register, pushes expected
// responses into a scoreboard queue on request accept and compares on response.
module tb_shift_cmd_seq;
  import shifter_pkg::*;

  typedef struct {
    logic [7:0]  data;
    logic        err;
    int          lat;
    int          cnt;
    logic [31:0] pack;
  } exp_t;

  logic clk;
  logic reset;

  shift_cmd_seq_if #(.DATA_W(8), .AMT_W(4)) bus ();

  shift_cmd_seq #(.DATA_W(8), .AMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  exp_t sb_q[$];

  int          sh_cnt = 0;
  logic [31:0] sh_pack = '0;
  logic [7:0]  sh_reg = '0;

  logic [1:0]  nxt_kind;
  logic [3:0]  nxt_amt;
  logic [7:0]  nxt_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural shifter register driven by the sequencer's command bus.
  always @(posedge clk) begin
    case (bus.op)
      OP_LOAD: sh_reg <= bus.d_in;
      OP_LSL:  sh_reg <= sh_reg << bus.shamt;
      OP_LSR:  sh_reg <= sh_reg >> bus.shamt;
      OP_ASR:  sh_reg <= 8'($signed(sh_reg) >>> bus.shamt);
      default: sh_reg <= sh_reg;
    endcase
  end
  assign bus.d_out = sh_reg;

  // Record each shift step issued, mid-cycle.
  always @(negedge clk) begin
    if (!reset && (bus.op == OP_LSL || bus.op == OP_LSR || bus.op == OP_ASR)) begin
      sh_cnt  = sh_cnt + 1;
      sh_pack = (sh_pack << 2) | 32'(bus.shamt);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_shift(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
    logic [7:0] r;
    case (k)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = 8'($signed(d) >>> a);
      default: r = d;
    endcase
    return r;
  endfunction

  // Present a request, wait for accept, push the expected response.
  task automatic send_req(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d,
                          output int waits);
    exp_t e;
    int   rem;
    int   s;
    bus.req_valid = 1'b1;
    bus.req_kind  = k;
    bus.req_amt   = a;
    bus.req_data  = d;
    waits = 0;
    while (!bus.req_ready && waits < 20) begin
      tick();
      waits++;
    end
    if (!bus.req_ready) check("accept_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sh_cnt  = 0;
    sh_pack = '0;
    e.data = ref_shift(k, a, d);
    e.err  = (k == 2'b11);
    e.cnt  = 0;
    e.pack = '0;
    if (k != 2'b11) begin
      rem = int'(a);
      while (rem > 0) begin
        s = (rem > 3) ? 3 : rem;
        e.pack = (e.pack << 2) | 32'(s);
        e.cnt++;
        rem -= s;
      end
    end
    e.lat = e.cnt + 2;
    sb_q.push_back(e);
    $display("[TB] req kind=%0d amt=%0d data=0x%02h accepted after %0d wait(s)", k, a, d, waits);
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall,
  // then complete the handshake (optionally offering the next request).
  task automatic get_rsp(input string tag, input int hold, input bit next_pending);
    exp_t       e;
    int         cyc;
    logic [7:0] first_data;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!bus.rsp_valid) begin
      check({tag, "_rsp_timeout"}, 32'(bus.rsp_valid), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_lat"},   32'(cyc),          32'(e.lat));
    check({tag, "_data"},  32'(bus.rsp_data), 32'(e.data));
    check({tag, "_err"},   32'(bus.rsp_err),  32'(e.err));
    check({tag, "_steps"}, 32'(sh_cnt),       32'(e.cnt));
    check({tag, "_seq"},   sh_pack,           e.pack);
    $display("[TB] rsp %s data=0x%02h err=%0d latency=%0d steps=%0d",
             tag, bus.rsp_data, bus.rsp_err, cyc, sh_cnt);
    first_data = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_data"},  32'(bus.rsp_data),  32'(first_data));
      check({tag, "_hold_op"},    32'(bus.op),        32'(OP_NOP));
      check({tag, "_hold_rdy"},   32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    if (next_pending) begin
      bus.req_valid = 1'b1;
      bus.req_kind  = nxt_kind;
      bus.req_amt   = nxt_amt;
      bus.req_data  = nxt_data;
      check({tag, "_no_accept_in_resp"}, 32'(bus.req_ready), 32'd0);
    end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int waits;
    bit rose;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_kind  = '0;
    bus.req_amt   = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_op",        32'(bus.op),        32'(OP_NOP));
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_d_in",      32'(bus.d_in),      32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    reset = 1'b0;
    #1;
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);

    send_req(2'b00, 4'd1, 8'h81, waits);
    check("t1_load_d_in", 32'(bus.d_in), 32'h81);
    get_rsp("t1_lsl", 0, 1'b0);
    tick();
    send_req(2'b01, 4'd7,  8'hF0, waits); get_rsp("t2_lsr7", 0, 1'b0); tick();
    send_req(2'b10, 4'd5,  8'h80, waits); get_rsp("t3_asr5", 0, 1'b0); tick();
    send_req(2'b00, 4'd12, 8'hFF, waits); get_rsp("t3_lsl12", 0, 1'b0); tick();
    send_req(2'b00, 4'd0,  8'h5A, waits); get_rsp("t4_amt0_lsl", 0, 1'b0); tick();
    send_req(2'b10, 4'd0,  8'h5A, waits); get_rsp("t4_amt0_asr", 0, 1'b0); tick();
    send_req(2'b11, 4'd4,  8'h3C, waits); get_rsp("t5_rsvd", 0, 1'b0); tick();
    send_req(2'b10, 4'd15, 8'h81, waits); get_rsp("big_asr15", 0, 1'b0); tick();
    send_req(2'b01, 4'd15, 8'hFF, waits); get_rsp("big_lsr15", 0, 1'b0); tick();
    send_req(2'b01, 4'd2,  8'hB7, waits); get_rsp("t6_stall", 4, 1'b0); tick();

    // Reset pulse during the second SHIFT cycle of an LSR by 9.
    send_req(2'b01, 4'd9, 8'hAA, waits);
    tick();
    tick();
    check("t7_in_shift", 32'(bus.op), 32'(OP_LSR));
    reset = 1'b1;
    #1;
    check("t7_rst_op", 32'(bus.op), 32'(OP_NOP));
    tick();
    reset = 1'b0;
    #1;
    void'(sb_q.pop_back());
    check("t7_idle_ready", 32'(bus.req_ready), 32'd1);
    check("t7_idle_op",    32'(bus.op),        32'(OP_NOP));
    rose = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid) rose = 1'b1;
      tick();
    end
    check("t7_no_rsp", 32'(rose), 32'd0);
    $display("[TB] reset mid-transaction dropped request");
    send_req(2'b00, 4'd3, 8'h11, waits); get_rsp("t7_after", 0, 1'b0); tick();

    // Back-to-back: next request offered during the RESP cycle.
    send_req(2'b00, 4'd4, 8'h0F, waits);
    nxt_kind = 2'b10;
    nxt_amt  = 4'd6;
    nxt_data = 8'hC3;
    get_rsp("t8_first", 0, 1'b1);
    send_req(nxt_kind, nxt_amt, nxt_data, waits);
    check("t8_accept_gap", 32'(waits), 32'd0);
    get_rsp("t8_second", 0, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
